// File: rtl/uart_tx_sched_if.sv
// Bundle of signals between the transmit scheduler, its frame producers and
// the byte-level UART TX core.
interface uart_tx_sched_if #(
  parameter int NREQ        = 4,
  parameter int FRAME_BYTES = 5
);
  logic [NREQ-1:0]               req_valid;
  logic [NREQ*FRAME_BYTES*8-1:0] req_data;
  logic [NREQ-1:0]               req_ready;
  logic                          uart_send;
  logic [7:0]                    send_data;
  logic                          uart_send_done;
  logic [3:0]                    uart_send_sta;
  logic [1:0]                    grant_id;
  logic                          busy;
  logic                          frame_done;
  logic [1:0]                    done_id;

  // Scheduler side
  modport master (
    input  req_valid, req_data, uart_send_done, uart_send_sta,
    output req_ready, uart_send, send_data, grant_id, busy, frame_done, done_id
  );

  // Producer / TX core side
  modport slave (
    output req_valid, req_data, uart_send_done, uart_send_sta,
    input  req_ready, uart_send, send_data, grant_id, busy, frame_done, done_id
  );
endinterface

// File: rtl/uart_tx_sched.sv
// Round-robin scheduler that buffers one frame per producer and serialises
// granted frames LSB byte first into a shared byte-level UART transmitter.
module uart_tx_sched #(
  parameter int         NREQ        = 4,
  parameter int         FRAME_BYTES = 5,
  parameter logic [3:0] BUSY_STA    = 4'd9
) (
  input logic             clk,
  input logic             rst,
  uart_tx_sched_if.master bus
);
  localparam int FW = FRAME_BYTES * 8;
  localparam int CW = (FRAME_BYTES > 1) ? $clog2(FRAME_BYTES) : 1;
  localparam logic [CW-1:0] LAST_BYTE = CW'(FRAME_BYTES - 1);

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] WAIT_RDY = 2'd1;
  localparam logic [1:0] SEND     = 2'd2;
  localparam logic [1:0] GAP      = 2'd3;

  logic [1:0]      state_reg, state_next;
  logic [1:0]      rr_reg, rr_next;
  logic [1:0]      grant_reg, grant_next;
  logic [CW-1:0]   byte_cnt_reg, byte_cnt_next;
  logic [FW-1:0]   frame_reg, frame_next;
  logic            send_reg, send_next;
  logic [7:0]      data_reg, data_next;
  logic            busy_reg, busy_next;
  logic            frame_done_reg, frame_done_next;
  logic [1:0]      done_id_reg, done_id_next;

  logic [NREQ-1:0] hold_valid_reg, hold_valid_next;
  logic [FW-1:0]   hold_data_reg [NREQ];
  logic [NREQ-1:0] load_vec, clear_vec, pending_vec;

  logic            pick_found;
  logic [1:0]      pick_idx;

  // Slot index k steps past the round-robin base, wrapped to NREQ
  function automatic logic [1:0] rr_index(input logic [1:0] base, input int k);
    int s;
    s = int'(base) + k;
    if (s >= NREQ) s = s - NREQ;
    return s[1:0];
  endfunction

  // Per-slot bookkeeping: a slot is released one cycle after its frame_done
  // pulse, so it cannot reload in the pulse cycle itself.
  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_slot
      assign clear_vec[gi]       = frame_done_reg && (done_id_reg == 2'(gi));
      assign load_vec[gi]        = !hold_valid_reg[gi] && bus.req_valid[gi];
      assign hold_valid_next[gi] = load_vec[gi] | (hold_valid_reg[gi] & ~clear_vec[gi]);
      assign pending_vec[gi]     = hold_valid_reg[gi] & ~clear_vec[gi];
      assign bus.req_ready[gi]   = ~hold_valid_reg[gi];
    end
  endgenerate

  // First pending slot in rotating order starting at rr
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = 2'd0;
    for (int k = 0; k < NREQ; k++) begin
      if (!pick_found && pending_vec[rr_index(rr_reg, k)]) begin
        pick_found = 1'b1;
        pick_idx   = rr_index(rr_reg, k);
      end
    end
  end

  // Frame sequencing: grant, wait for TX ready, hold send until done, gap
  always_comb begin
    state_next      = state_reg;
    rr_next         = rr_reg;
    grant_next      = grant_reg;
    byte_cnt_next   = byte_cnt_reg;
    frame_next      = frame_reg;
    send_next       = send_reg;
    data_next       = data_reg;
    busy_next       = busy_reg;
    frame_done_next = 1'b0;
    done_id_next    = done_id_reg;
    case (state_reg)
      IDLE: begin
        if (pick_found) begin
          grant_next    = pick_idx;
          frame_next    = hold_data_reg[pick_idx];
          data_next     = hold_data_reg[pick_idx][7:0];
          byte_cnt_next = '0;
          busy_next     = 1'b1;
          state_next    = WAIT_RDY;
        end
      end
      WAIT_RDY: begin
        if (bus.uart_send_sta != BUSY_STA) begin
          send_next  = 1'b1;
          state_next = SEND;
        end
      end
      SEND: begin
        if (bus.uart_send_done) begin
          send_next = 1'b0;
          if (byte_cnt_reg == LAST_BYTE) begin
            frame_done_next = 1'b1;
            done_id_next    = grant_reg;
            rr_next         = (grant_reg == 2'(NREQ - 1)) ? 2'd0 : grant_reg + 2'd1;
            busy_next       = 1'b0;
            state_next      = IDLE;
          end else begin
            state_next = GAP;
          end
        end
      end
      GAP: begin
        byte_cnt_next = byte_cnt_reg + 1'b1;
        frame_next    = frame_reg >> 8;
        data_next     = frame_reg[15:8];
        state_next    = WAIT_RDY;
      end
      default: state_next = IDLE;
    endcase
  end

  // Control and output registers; reset drops any partial frame silently
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= IDLE;
      rr_reg         <= 2'd0;
      grant_reg      <= 2'd0;
      byte_cnt_reg   <= '0;
      frame_reg      <= '0;
      send_reg       <= 1'b0;
      data_reg       <= 8'h00;
      busy_reg       <= 1'b0;
      frame_done_reg <= 1'b0;
      done_id_reg    <= 2'd0;
      hold_valid_reg <= '0;
    end else begin
      state_reg      <= state_next;
      rr_reg         <= rr_next;
      grant_reg      <= grant_next;
      byte_cnt_reg   <= byte_cnt_next;
      frame_reg      <= frame_next;
      send_reg       <= send_next;
      data_reg       <= data_next;
      busy_reg       <= busy_next;
      frame_done_reg <= frame_done_next;
      done_id_reg    <= done_id_next;
      hold_valid_reg <= hold_valid_next;
    end
  end

  // Frame capture into holding slots; contents only matter while valid
  always_ff @(posedge clk) begin
    for (int i = 0; i < NREQ; i++) begin
      if (load_vec[i]) hold_data_reg[i] <= bus.req_data[i*FW +: FW];
    end
  end

  assign bus.uart_send  = send_reg;
  assign bus.send_data  = data_reg;
  assign bus.grant_id   = grant_reg;
  assign bus.busy       = busy_reg;
  assign bus.frame_done = frame_done_reg;
  assign bus.done_id    = done_id_reg;
endmodule

// File: tb/tb_uart_tx_sched.sv
// Directed bench for uart_tx_sched with a behavioural UART TX core that
// finishes each byte 10 cycles after uart_send rises.
module tb_uart_tx_sched;
  localparam int NREQ = 4;
  localparam int FB   = 5;
  localparam int FW   = FB * 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  uart_tx_sched_if #(.NREQ(NREQ), .FRAME_BYTES(FB)) bus ();

  uart_tx_sched #(.NREQ(NREQ), .FRAME_BYTES(FB), .BUSY_STA(4'd9)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int viol     = 0;
  int tx_cnt   = 0;
  logic [7:0] byte_q[$];
  logic [1:0] byte_id_q[$];
  logic [1:0] done_q[$];
  logic [7:0] prev_data = 8'h00;
  logic       prev_send = 1'b0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_frame_done(input string tag);
    int i;
    i = 0;
    tick();
    while (!bus.frame_done && i < 400) begin
      tick();
      i++;
    end
    check_val({tag, "_frame_done_seen"}, 64'(bus.frame_done), 64'd1);
  endtask

  task automatic check_frame(input string tag, input int base, input logic [39:0] fr,
                             input logic [1:0] id);
    for (int k = 0; k < FB; k++) begin
      if (base + k < byte_q.size()) begin
        check_val($sformatf("%s_byte%0d", tag, k), 64'(byte_q[base+k]), 64'(fr[8*k +: 8]));
        check_val($sformatf("%s_id%0d", tag, k), 64'(byte_id_q[base+k]), 64'(id));
      end
    end
  endtask

  task automatic offer(input logic [NREQ-1:0] mask);
    bus.req_valid = mask;
    tick();
    bus.req_valid = '0;
  endtask

  // TX core model plus protocol monitor, evaluated on the falling edge
  initial begin
    bus.uart_send_done = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        tx_cnt = 0;
        bus.uart_send_done = 1'b0;
      end else if (bus.uart_send_done) begin
        bus.uart_send_done = 1'b0;
        tx_cnt = 0;
      end else if (bus.uart_send) begin
        tx_cnt++;
        if (tx_cnt == 10) begin
          bus.uart_send_done = 1'b1;
          byte_q.push_back(bus.send_data);
          byte_id_q.push_back(bus.grant_id);
          $display("byte %02h sent for requester %0d", bus.send_data, bus.grant_id);
        end
      end else begin
        tx_cnt = 0;
      end
      if (bus.frame_done) begin
        done_q.push_back(bus.done_id);
        $display("frame done for requester %0d", bus.done_id);
        if (bus.uart_send) viol++;
      end
      if (prev_send && bus.uart_send && bus.send_data != prev_data) viol++;
      prev_send = bus.uart_send;
      prev_data = bus.send_data;
    end
  end

  initial begin
    logic [39:0] fa, f0, f1, f2, f3, fc, fd, fe, ff, fg;
    int done_cnt;
    int i;
    fa = 40'h05_04_03_02_01;
    f0 = 40'h14_13_12_11_10;
    f1 = 40'h24_23_22_21_20;
    f2 = 40'h34_33_32_31_30;
    f3 = 40'h44_43_42_41_40;
    fc = 40'h9E_9D_9C_9B_9A;
    fd = 40'hD5_D4_D3_D2_D1;
    fe = 40'hE5_E4_E3_E2_E1;
    ff = 40'hF5_F4_F3_F2_F1;
    fg = 40'h6A_5B_4C_3D_2E;

    rst = 1'b1;
    bus.req_valid = '0;
    bus.req_data = '0;
    bus.uart_send_sta = 4'd0;
    repeat (3) tick();
    check_val("rst_uart_send", 64'(bus.uart_send), 64'd0);
    check_val("rst_send_data", 64'(bus.send_data), 64'h00);
    check_val("rst_grant_id", 64'(bus.grant_id), 64'd0);
    check_val("rst_busy", 64'(bus.busy), 64'd0);
    check_val("rst_frame_done", 64'(bus.frame_done), 64'd0);
    check_val("rst_done_id", 64'(bus.done_id), 64'd0);
    rst = 1'b0;
    tick();
    check_val("rst_req_ready", 64'(bus.req_ready), 64'hF);

    // Single frame from requester 0 with latency checks
    byte_q.delete(); byte_id_q.delete(); done_q.delete();
    bus.req_data[0*FW +: FW] = fa;
    offer(4'b0001);
    check_val("t1_c1_ready0", 64'(bus.req_ready[0]), 64'd0);
    check_val("t1_c1_busy", 64'(bus.busy), 64'd0);
    tick();
    check_val("t1_c2_busy", 64'(bus.busy), 64'd1);
    check_val("t1_c2_send", 64'(bus.uart_send), 64'd0);
    check_val("t1_c2_data", 64'(bus.send_data), 64'h01);
    check_val("t1_c2_grant", 64'(bus.grant_id), 64'd0);
    tick();
    check_val("t1_c3_send", 64'(bus.uart_send), 64'd1);
    wait_frame_done("t1");
    check_val("t1_done_id", 64'(bus.done_id), 64'd0);
    check_val("t1_done_send_low", 64'(bus.uart_send), 64'd0);
    check_val("t1_done_ready0", 64'(bus.req_ready[0]), 64'd0);
    tick();
    check_val("t1_after_ready0", 64'(bus.req_ready[0]), 64'd1);
    check_val("t1_after_frame_done", 64'(bus.frame_done), 64'd0);
    check_val("t1_nbytes", 64'(byte_q.size()), 64'd5);
    check_frame("t1", 0, fa, 2'd0);
    check_val("t1_ndone", 64'(done_q.size()), 64'd1);

    // Three simultaneous requesters from rr = 0
    rst = 1'b1; tick(); rst = 1'b0; tick();
    byte_q.delete(); byte_id_q.delete(); done_q.delete();
    bus.req_data[0*FW +: FW] = f0;
    bus.req_data[1*FW +: FW] = f1;
    bus.req_data[2*FW +: FW] = f2;
    offer(4'b0111);
    wait_frame_done("t2a");
    wait_frame_done("t2b");
    wait_frame_done("t2c");
    tick();
    check_val("t2_nbytes", 64'(byte_q.size()), 64'd15);
    check_frame("t2_f0", 0, f0, 2'd0);
    check_frame("t2_f1", 5, f1, 2'd1);
    check_frame("t2_f2", 10, f2, 2'd2);
    check_val("t2_ndone", 64'(done_q.size()), 64'd3);
    if (done_q.size() == 3) begin
      check_val("t2_order0", 64'(done_q[0]), 64'd0);
      check_val("t2_order1", 64'(done_q[1]), 64'd1);
      check_val("t2_order2", 64'(done_q[2]), 64'd2);
    end

    // rr = 3 with requesters 3 and 0 pending: wraps 3 then 0
    byte_q.delete(); byte_id_q.delete(); done_q.delete();
    bus.req_data[3*FW +: FW] = f3;
    bus.req_data[0*FW +: FW] = f0;
    offer(4'b1001);
    wait_frame_done("t3a");
    wait_frame_done("t3b");
    tick();
    check_frame("t3_f3", 0, f3, 2'd3);
    check_frame("t3_f0", 5, f0, 2'd0);
    check_val("t3_ndone", 64'(done_q.size()), 64'd2);
    if (done_q.size() == 2) begin
      check_val("t3_order0", 64'(done_q[0]), 64'd3);
      check_val("t3_order1", 64'(done_q[1]), 64'd0);
    end
    // rr must now be 1: requesters 0 and 1 pending serve 1 first
    done_q.delete();
    offer(4'b0011);
    wait_frame_done("t3c");
    check_val("t3_rr1_first", 64'(bus.done_id), 64'd1);
    wait_frame_done("t3d");
    check_val("t3_rr1_second", 64'(bus.done_id), 64'd0);
    tick();

    // TX core busy for 20 cycles in WAIT_RDY
    byte_q.delete(); byte_id_q.delete(); done_q.delete();
    bus.uart_send_sta = 4'd9;
    bus.req_data[2*FW +: FW] = fc;
    offer(4'b0100);
    tick();
    done_cnt = 0;
    for (int k = 0; k < 20; k++) begin
      if (bus.uart_send !== 1'b0 || bus.send_data !== 8'h9A || bus.busy !== 1'b1) done_cnt++;
      tick();
    end
    check_val("t4_held_cycles_bad", 64'(done_cnt), 64'd0);
    check_val("t4_send_before", 64'(bus.uart_send), 64'd0);
    bus.uart_send_sta = 4'd0;
    tick();
    check_val("t4_send_after", 64'(bus.uart_send), 64'd1);
    check_val("t4_data_after", 64'(bus.send_data), 64'h9A);
    wait_frame_done("t4");
    tick();
    check_frame("t4", 0, fc, 2'd2);

    // Requester 1 re-offers in its frame_done cycle
    byte_q.delete(); byte_id_q.delete(); done_q.delete();
    bus.req_data[1*FW +: FW] = fd;
    offer(4'b0010);
    wait_frame_done("t5a");
    bus.req_data[1*FW +: FW] = fe;
    bus.req_valid = 4'b0010;
    check_val("t5_ready_in_done", 64'(bus.req_ready[1]), 64'd0);
    tick();
    check_val("t5_ready_next", 64'(bus.req_ready[1]), 64'd1);
    tick();
    bus.req_valid = '0;
    check_val("t5_accepted", 64'(bus.req_ready[1]), 64'd0);
    wait_frame_done("t5b");
    tick();
    check_val("t5_nbytes", 64'(byte_q.size()), 64'd10);
    check_frame("t5_first", 0, fd, 2'd1);
    check_frame("t5_second", 5, fe, 2'd1);

    // Reset during byte 2 drops the frame silently
    byte_q.delete(); byte_id_q.delete(); done_q.delete();
    bus.req_data[3*FW +: FW] = ff;
    offer(4'b1000);
    i = 0;
    while (!(byte_q.size() == 2 && bus.uart_send) && i < 300) begin
      tick();
      i++;
    end
    check_val("t6_reach_byte2", 64'(byte_q.size() == 2 && bus.uart_send), 64'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_val("t6_send", 64'(bus.uart_send), 64'd0);
    check_val("t6_busy", 64'(bus.busy), 64'd0);
    check_val("t6_ready", 64'(bus.req_ready), 64'hF);
    check_val("t6_frame_done", 64'(bus.frame_done), 64'd0);
    check_val("t6_send_data", 64'(bus.send_data), 64'h00);
    repeat (30) tick();
    check_val("t6_no_done", 64'(done_q.size()), 64'd0);
    byte_q.delete(); byte_id_q.delete();
    bus.req_data[3*FW +: FW] = fg;
    offer(4'b1000);
    wait_frame_done("t6");
    tick();
    check_val("t6_nbytes", 64'(byte_q.size()), 64'd5);
    check_frame("t6_new", 0, fg, 2'd3);

    check_val("protocol_violations", 64'(viol), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/uart_tx_sched.md
# uart_tx_sched

Round-robin transmit scheduler sharing one byte-level UART transmitter among NREQ frame producers (key scanner, note engine, debug status). Each producer hands over a 40-bit frame. The block buffers one frame per producer, grants the UART in rotating order, and serialises the granted frame LSB-byte-first with the transmitter's send/done/status handshake. It sits between the producer blocks and the UART TX core, replacing per-producer frame senders.

## Interface
- NREQ, 4: number of requesters; 2..4 supported, grant index is 2 bits.
- FRAME_BYTES, 5: bytes per frame; frame width is FRAME_BYTES*8 = 40.
- BUSY_STA, 9: uart_send_sta value meaning the transmitter is not ready to take a byte.
- clk  in  1  system clock; single clock domain.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  NREQ  per-requester frame offer.
- req_data  in  NREQ*40  frames; requester i uses bits [40*i+39:40*i].
- req_ready  out  NREQ  requester i's holding slot is empty.
- uart_send  out  1  byte-send request to the UART TX core.
- send_data  out  8  byte presented to the UART TX core.
- uart_send_done  in  1  TX core has finished the current byte (sampled level).
- uart_send_sta  in  4  TX core state; equals BUSY_STA when busy.
- grant_id  out  2  index of the requester currently being serviced.
- busy  out  1  a frame is in flight (state is not IDLE).
- frame_done  out  1  one-cycle pulse when the last byte of a frame completes.
- done_id  out  2  requester index qualified by frame_done.

## Operation
- Holding slots: hold_valid[i] and hold_data[i].
  - req_ready[i] = !hold_valid[i] (registered-state based, no combinational path from req_valid).
  - Accept when req_valid[i] && req_ready[i]: the slot loads at that edge.
  - A slot clears on the edge that ends its frame. req_ready[i] rises the following cycle, so a frame cannot be accepted in the cycle its slot clears.
- Round-robin pointer rr (2 bits, reset 0): search order is rr, rr+1, … modulo NREQ. After a frame completes, rr = granted index + 1, wrapping NREQ-1 to 0.
- FSM states: IDLE, WAIT_RDY, SEND, GAP.
  - IDLE: if any hold_valid, pick the first valid slot in rr order, then:
    - latch grant_id and copy the frame to a shift register;
    - load send_data with byte 0 (bits [7:0]);
    - set byte_cnt = 0 and go to WAIT_RDY.
  - WAIT_RDY: if uart_send_sta == BUSY_STA, stay with uart_send=0. Otherwise uart_send=1 and go to SEND.
  - SEND: hold uart_send=1 and send_data stable until uart_send_done=1.
    - If byte_cnt == FRAME_BYTES-1: clear hold_valid[grant_id], pulse frame_done with done_id=grant_id, update rr, go to IDLE.
    - Otherwise: go to GAP.
  - GAP: uart_send=0, byte_cnt+1, send_data = next byte (bits [8k+7:8k]), go to WAIT_RDY.
- Byte order is fixed: [7:0], [15:8], [23:16], [31:24], [39:32].
- Frames from one requester are never interleaved with another's. The grant is held until all FRAME_BYTES bytes are done.
- Requester inputs are ignored once a slot is full. The in-flight frame uses the captured copy, not live req_data.
- Reset (any cycle, including mid-byte): state=IDLE, every hold_valid=0, rr=0, byte_cnt=0. The partial frame is dropped with no frame_done.

## Timing
- Reset values:
  - uart_send=0, send_data=8'h00, grant_id=0;
  - busy=0, frame_done=0, done_id=0;
  - req_ready = all ones from the first cycle after reset.
- Latency with the TX core idle and no other traffic:
  - accept edge at cycle 0;
  - hold_valid seen in cycle 1; grant edge ends cycle 1;
  - WAIT_RDY in cycle 2; uart_send=1 from cycle 3.
- uart_send is deasserted for at least 1 cycle (GAP) between bytes. uart_send_done is never sampled outside SEND.
- frame_done is high during the cycle after the edge where the last uart_send_done is sampled. uart_send=0 in that cycle.
- Back-to-back frames: IDLE takes 1 cycle, so there is a minimum 2-cycle uart_send-low gap between frames.
- All outputs are registered.

## Test plan
- Single frame, requester 0, data 40'h05_04_03_02_01, TX core completes each byte 10 cycles after uart_send -> send_data sequence 01,02,03,04,05; one frame_done with done_id=0; req_ready[0] low from cycle 1 until the cycle after frame_done.
- Requesters 0,1,2 all valid in the same cycle, rr=0 -> frames serviced in order 0,1,2; no byte interleaving; rr ends at 3.
- rr=3 with requesters 3 and 0 pending -> 3 served first, then 0 (wrap); rr ends at 1.
- uart_send_sta held at 9 for 20 cycles in WAIT_RDY -> uart_send stays 0 and send_data stable; uart_send rises the cycle after sta leaves 9.
- Requester 1 re-offers a new frame in its frame_done cycle -> not accepted that cycle (req_ready[1]=0); accepted next cycle; second frame sent with its own data.
- rst pulsed during byte 2 of a frame -> next cycle: uart_send=0, busy=0, req_ready all ones, no frame_done; a new frame afterwards starts from byte 0.
